// File: rtl/addsub_share_arbiter.sv
// Round-robin front end that time-shares one pipelined add/subtract unit among
// NUM_REQ requesters, routing each result back via a latency-matched tag pipeline.
module addsub_share_arbiter #(
    parameter int DATAWIDTH = 8,
    parameter int NUM_REQ   = 3,
    parameter int LATENCY   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   req_a,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   req_b,
    input  logic [NUM_REQ-1:0]             req_op,
    input  logic [NUM_REQ-1:0]             req_en,
    output logic [DATAWIDTH-1:0]           au_a,
    output logic [DATAWIDTH-1:0]           au_b,
    output logic                           au_op,
    output logic                           au_valid,
    input  logic [DATAWIDTH-1:0]           au_result,
    input  logic                           au_carry,
    input  logic                           au_valid_out,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATAWIDTH-1:0]           rsp_result,
    output logic                           rsp_carry,
    output logic [$clog2(LATENCY+1)-1:0]   in_flight,
    output logic                           err_tag
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(LATENCY+1);

    logic [IDW-1:0]     rr_ptr_reg;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     winner_id;
    logic               have_grant;
    logic               tag_valid_reg [LATENCY];
    logic [IDW-1:0]     tag_id_reg    [LATENCY];
    logic               tag_out_valid;
    logic [IDW-1:0]     tag_out_id;
    logic [CW-1:0]      count_reg;
    logic [CW-1:0]      count_next;
    logic               err_tag_reg;

    assign eligible = rst ? '0 : (req_valid & req_en);

    // Scan offsets from highest to lowest so the one closest to rr_ptr wins.
    always_comb begin
        logic [IDW:0] idx;
        winner_id  = '0;
        have_grant = 1'b0;
        idx        = '0;
        for (int k = NUM_REQ-1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr_reg} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NUM_REQ)) begin
                idx = idx - (IDW+1)'(NUM_REQ);
            end
            if (eligible[idx[IDW-1:0]]) begin
                winner_id  = idx[IDW-1:0];
                have_grant = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
            assign grant[gi] = have_grant && (winner_id == IDW'(gi));
        end
    endgenerate

    assign req_ready = grant;
    assign au_valid  = have_grant;

    always_comb begin
        au_a  = '0;
        au_b  = '0;
        au_op = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                au_a  = req_a[i*DATAWIDTH +: DATAWIDTH];
                au_b  = req_b[i*DATAWIDTH +: DATAWIDTH];
                au_op = req_op[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg <= '0;
        end else if (have_grant) begin
            rr_ptr_reg <= (winner_id == IDW'(NUM_REQ-1)) ? '0 : winner_id + IDW'(1);
        end
    end

    // The tag rides alongside the unit's pipeline so its exit lines up with au_valid_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < LATENCY; s++) begin
                tag_valid_reg[s] <= 1'b0;
                tag_id_reg[s]    <= '0;
            end
        end else begin
            tag_valid_reg[0] <= au_valid;
            tag_id_reg[0]    <= winner_id;
            for (int s = 1; s < LATENCY; s++) begin
                tag_valid_reg[s] <= tag_valid_reg[s-1];
                tag_id_reg[s]    <= tag_id_reg[s-1];
            end
        end
    end

    assign tag_out_valid = tag_valid_reg[LATENCY-1];
    assign tag_out_id    = tag_id_reg[LATENCY-1];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
            assign rsp_valid[gi] = tag_out_valid && (tag_out_id == IDW'(gi));
        end
    endgenerate

    assign rsp_result = tag_out_valid ? au_result : '0;
    assign rsp_carry  = tag_out_valid ? au_carry  : 1'b0;

    // in_flight already counts this cycle's issue and excludes this cycle's exit.
    always_comb begin
        case ({au_valid, tag_out_valid})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    assign in_flight = count_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg   <= '0;
            err_tag_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (au_valid_out != tag_out_valid) begin
                err_tag_reg <= 1'b1;
            end
        end
    end

    assign err_tag = err_tag_reg;

endmodule

// File: tb/tb_addsub_share_arbiter.sv
// Randomized and directed scoreboard bench for addsub_share_arbiter with a
// behavioural pipelined add/subtract unit attached.
module tb_addsub_share_arbiter;

    localparam int DW = 8;
    localparam int N  = 3;
    localparam int L  = 4;
    localparam int CW = $clog2(L+1);

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid, req_ready, req_op, req_en;
    logic [N*DW-1:0]   req_a, req_b;
    logic [DW-1:0]     au_a, au_b, au_result;
    logic              au_op, au_valid, au_carry, au_valid_out;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_result;
    logic              rsp_carry;
    logic [CW-1:0]     in_flight;
    logic              err_tag;

    always #5 clk = ~clk;

    addsub_share_arbiter #(.DATAWIDTH(DW), .NUM_REQ(N), .LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_en(req_en),
        .au_a(au_a), .au_b(au_b), .au_op(au_op), .au_valid(au_valid),
        .au_result(au_result), .au_carry(au_carry), .au_valid_out(au_valid_out),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_carry(rsp_carry),
        .in_flight(in_flight), .err_tag(err_tag)
    );

    // Shared unit: LATENCY stages, subtract as A + ~B + 1, inject forces a stray o_valid.
    logic [DW-1:0] u_res [L];
    logic          u_c   [L];
    logic          u_v   [L];
    logic          inject;

    function automatic logic [DW:0] unit_calc(input logic [DW-1:0] a, b, input logic op);
        if (op) return {1'b0, a} + {1'b0, ~b} + (DW+1)'(1);
        return {1'b0, a} + {1'b0, b};
    endfunction

    always @(posedge clk) begin
        logic [DW:0] f;
        f = unit_calc(au_a, au_b, au_op);
        u_res[0] <= f[DW-1:0];
        u_c[0]   <= f[DW];
        u_v[0]   <= rst ? 1'b0 : au_valid;
        for (int s = 1; s < L; s++) begin
            u_res[s] <= u_res[s-1];
            u_c[s]   <= u_c[s-1];
            u_v[s]   <= rst ? 1'b0 : u_v[s-1];
        end
    end

    assign au_result    = u_res[L-1];
    assign au_carry     = u_c[L-1];
    assign au_valid_out = u_v[L-1] | inject;

    typedef struct {
        int          due;
        int          id;
        logic [7:0]  res;
        logic        c;
    } exp_t;

    exp_t sbq[$];
    int   hist[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   rr = 0;
    bit   exp_err = 0;
    bit   started = 0;
    exp_t e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic op);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
        req_op[i]         = op;
    endtask

    // Reference model: checks the current cycle at the falling edge, then advances.
    task automatic tick();
        int          g;
        int          idx;
        int          a, b, s;
        logic [N-1:0] eg;
        exp_t        x;
        @(negedge clk);
        if (rst) begin
            chk("ready_in_rst", 32'(req_ready), 32'd0);
            chk("au_valid_in_rst", 32'(au_valid), 32'd0);
            rr = 0;
            sbq.delete();
            hist.delete();
            exp_err = 0;
        end else begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                idx = (rr + k) % N;
                if (g < 0 && req_valid[idx] && req_en[idx]) g = idx;
            end
            eg = (g >= 0) ? N'(1 << g) : '0;
            chk("req_ready", 32'(req_ready), 32'(eg));
            chk("au_valid", 32'(au_valid), (g >= 0) ? 32'd1 : 32'd0);
            if (g >= 0) begin
                a = int'(req_a[g*DW +: DW]);
                b = int'(req_b[g*DW +: DW]);
                chk("au_operands", {15'd0, au_a, au_b, au_op}, {15'd0, req_a[g*DW +: DW], req_b[g*DW +: DW], req_op[g]});
                if (req_op[g]) begin
                    x.res = 8'((a - b + 256) % 256);
                    x.c   = (a >= b);
                end else begin
                    s     = a + b;
                    x.res = 8'(s % 256);
                    x.c   = (s >= 256);
                end
                x.due = cyc + L;
                x.id  = g;
                sbq.push_back(x);
                hist.push_back(cyc);
                rr = (g + 1) % N;
            end else begin
                chk("au_idle_zero", {15'd0, au_a, au_b, au_op}, 32'd0);
            end
            while (hist.size() > 0 && hist[0] <= cyc - L) void'(hist.pop_front());
            chk("in_flight", 32'(in_flight), 32'(hist.size()));
            chk("err_tag", 32'(err_tag), 32'(exp_err));
            if (inject) exp_err = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        repeat (n) tick();
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    always @(negedge clk) begin
        if (started && !rst) begin
            if (rsp_valid != '0) begin
                if (sbq.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    $display("rsp cyc=%0d id=%0d result=%02h carry=%0d", cyc, e.id, rsp_result, rsp_carry);
                    chk("rsp_cycle", 32'(cyc), 32'(e.due));
                    chk("rsp_valid", 32'(rsp_valid), 32'(1 << e.id));
                    chk("rsp_result", 32'(rsp_result), 32'(e.res));
                    chk("rsp_carry", 32'(rsp_carry), 32'(e.c));
                end
            end else begin
                chk("rsp_idle_zero", {23'd0, rsp_result, rsp_carry}, 32'd0);
                if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                    e = sbq.pop_front();
                    chk("rsp_missing", 32'(rsp_valid), 32'(1 << e.id));
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        inject    = 1'b0;
        req_valid = '0;
        req_en    = '1;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        @(posedge clk);
        #1;
        started = 1;
        tick();
        rst = 1'b0;
        idle(8);

        // single add on requester 0
        set_op(0, 8'h05, 8'h03, 1'b0);
        req_valid = 3'b001;
        tick();
        idle(6);

        // subtract with borrow, then add with wraparound, back to back on requester 1
        set_op(1, 8'h03, 8'h05, 1'b1);
        req_valid = 3'b010;
        tick();
        set_op(1, 8'hFF, 8'h01, 1'b0);
        tick();
        idle(6);

        // reset while two operations are in flight
        set_op(0, 8'h10, 8'h20, 1'b0);
        set_op(2, 8'h30, 8'h40, 1'b1);
        req_valid = 3'b101;
        tick();
        tick();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(6);

        // full contention from rr_ptr=0
        set_op(0, 8'h11, 8'h22, 1'b0);
        set_op(1, 8'h80, 8'h80, 1'b0);
        set_op(2, 8'h40, 8'h41, 1'b1);
        req_valid = 3'b111;
        repeat (6) tick();
        idle(6);

        // skip over idle requester, then mask out the only requester
        req_valid = 3'b001;
        tick();
        req_valid = 3'b101;
        tick();
        tick();
        req_en    = 3'b110;
        req_valid = 3'b001;
        tick();
        req_en = '1;
        idle(6);

        // stray o_valid with an empty tag pipeline
        inject = 1'b1;
        tick();
        inject = 1'b0;
        idle(4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(3);

        // randomized traffic
        repeat (400) begin
            req_valid = N'($urandom);
            req_en    = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
            for (int i = 0; i < N; i++) set_op(i, 8'($urandom), 8'($urandom), 1'($urandom));
            tick();
        end
        req_en = '1;
        idle(8);

        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/addsub_share_arbiter.md
Name: addsub_share_arbiter

Overview:
- Shares one pipelined add/subtract unit among NUM_REQ requesters.
- Each cycle, round-robin arbitration selects at most one request and issues it into the unit.
- A requester-ID tag travels in a shift register that matches the unit latency, so each result returns to the requester that issued it.
- Sits between client blocks and a single add/subtract instance. Supplies a consistency check against the unit's output valid.

Parameters:
- DATAWIDTH, 8, operand/result width; must equal the shared unit's width.
- NUM_REQ, 3, number of requesters, 2..8.
- LATENCY, 4, unit cycles from i_valid to o_valid; equals the unit's pipeline stage count.
- IDW, $clog2(NUM_REQ), tag width (derived localparam, not overridable).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset; also drives the shared unit's rst.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i]&req_ready[i].
- req_a  in  NUM_REQ*DATAWIDTH  packed operand A; requester i occupies slice [i*DATAWIDTH +: DATAWIDTH].
- req_b  in  NUM_REQ*DATAWIDTH  packed operand B, same packing.
- req_op  in  NUM_REQ  0=add, 1=subtract.
- req_en  in  NUM_REQ  requester enable mask; disabled requesters are never granted.
- au_a, au_b  out  DATAWIDTH  operands to the unit.
- au_op  out  1  op to the unit.
- au_valid  out  1  i_valid to the unit.
- au_result  in  DATAWIDTH  unit Result.
- au_carry  in  1  unit carry_borrow.
- au_valid_out  in  1  unit o_valid.
- rsp_valid  out  NUM_REQ  one-hot response strobe, single cycle.
- rsp_result  out  DATAWIDTH  result, shared bus.
- rsp_carry  out  1  carry/borrow, shared.
- in_flight  out  $clog2(LATENCY+1)  operations issued and not yet returned.
- err_tag  out  1  sticky: au_valid_out disagreed with the tag pipeline.

Behaviour:
- Reset values: rr_ptr=0, tag pipeline valids=0, in_flight=0, err_tag=0. This gives rsp_valid=0 the cycle after rst is sampled high. While rst=1, req_ready=0 and au_valid=0.
- Arbitration is combinational within the cycle. Eligible set = req_valid & req_en. Pick the first eligible index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
- req_ready is one-hot on the winner and 0 elsewhere. It does not depend on the winner's later behaviour; the unit never stalls, so there is no backpressure.
- au_a/au_b/au_op are muxed from the winner; au_valid=1 iff a winner exists. With no winner: au_valid=0, and au_a/au_b/au_op are don't-care but held at 0.
- rr_ptr update: after a grant to index g, rr_ptr <= (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Tag pipeline: LATENCY entries of {valid, id[IDW-1:0]}. Stage 0 loads {au_valid, winner}; it shifts every cycle.
- The tag exits in the same cycle the unit asserts au_valid_out for that issue. Request accepted in cycle T gives the response in cycle T+LATENCY.
- Response is combinational from the tag output and unit outputs:
  - rsp_valid[id]=tag_out.valid (all other bits 0).
  - rsp_result=au_result, rsp_carry=au_carry.
  - If tag_out.valid=0: rsp_result=0 and rsp_carry=0.
- Responses carry no backpressure; requesters must always accept them.
- in_flight counter rules:
  - +1 on issue, -1 on tag exit; both in one cycle means no change.
  - Never exceeds LATENCY, since at most one issue per cycle.
- err_tag is set when au_valid_out != tag_out.valid. It stays set until rst. Responses continue to follow the tag pipeline, not au_valid_out.
- Reset mid-operation: all in-flight tags are discarded, no response is delivered for them, and in_flight returns to 0. The unit is reset by the same rst, so no stray au_valid_out is expected.
- Subtract: the unit computes A + ~B + 1; rsp_carry=1 means no borrow (A>=B unsigned). The arbiter does not reinterpret this.
- Throughput is one issue per cycle total. Under full contention, each requester gets 1/NUM_REQ of the issue slots.
- Target size: 150-300 lines of RTL.

Test Plan (DATAWIDTH=8, NUM_REQ=3, LATENCY=4, behavioural unit model unless noted):
- Single add: req0 A=0x05 B=0x03 op=0 at cycle 10 -> req_ready=3'b001 at 10. At 14: rsp_valid=3'b001, rsp_result=0x08, rsp_carry=0, in_flight=1 during 10..13.
- Subtract and overflow: req1 0x03-0x05 -> 0xFE, carry=0. Next cycle, req1 0xFF+0x01 -> 0x00, carry=1. Both responses arrive on consecutive cycles, in order.
- Full contention: all three req_valid=1 for 6 cycles from rr_ptr=0 -> grants 0,1,2,0,1,2. rsp_valid follows the same sequence 4 cycles later; in_flight peaks at 4.
- Skip and mask: rr_ptr=1, req_valid=3'b101, req_en=3'b111 -> grant 2 then 0. Then req_en=3'b110 with req_valid=3'b001 -> no grant, au_valid=0.
- Reset mid-flight: issue 2 ops, assert rst for 1 cycle before they return -> no rsp_valid for either, in_flight=0, rr_ptr=0, err_tag=0.
- Tag check: model injects au_valid_out=1 with the tag pipeline empty -> err_tag=1 next cycle and stays 1; rsp_valid stays 0; rst clears err_tag.
